// File: rtl/img_pkg.sv
// Shared constants and types for the binary image-processing stages.
package img_pkg;
    localparam int unsigned PIX_W          = 24;
    localparam int unsigned IMG_WIDTH_DEF  = 640;
    localparam int unsigned IMG_HEIGHT_DEF = 480;

    localparam logic [PIX_W-1:0] WHITE = 24'hFFFFFF;
    localparam logic [PIX_W-1:0] BLACK = 24'h000000;

    // 3x3 binary window; bit 0 of each row is the newest column.
    typedef struct packed {
        logic [2:0] top;
        logic [2:0] mid;
        logic [2:0] bot;
    } window_t;

    function automatic logic [PIX_W-1:0] replicate(input logic b);
        return {PIX_W{b}};
    endfunction
endpackage

// File: rtl/line_buffer_1b.sv
// Single-address 1-bit RAM with read-first behaviour (combinational read of pre-write data).
module line_buffer_1b #(
    parameter int unsigned DEPTH = 640,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic          din,
    output logic          dout
);
    logic mem [DEPTH];

    // Old contents stay visible until the write lands at the clock edge.
    assign dout = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end
endmodule

// File: rtl/img_erode3x3.sv
// Binary 3x3 erosion over a replicated 24-bit pixel stream, fixed 2-cycle latency.
module img_erode3x3
    import img_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int unsigned IMG_HEIGHT = IMG_HEIGHT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vsync_i,
    input  logic [PIX_W-1:0] img_data_i,
    input  logic             valid_i,
    output logic [PIX_W-1:0] img_data_o,
    output logic             valid_o
);
    localparam int unsigned COL_W = $clog2(IMG_WIDTH);
    localparam int unsigned ROW_W = $clog2(IMG_HEIGHT);

    logic [COL_W-1:0] col;
    logic [COL_W-1:0] col_cur;
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] row_cur;
    logic             pix_bit;
    logic             t1;
    logic             t2;
    logic             last_col;
    logic             last_row;
    logic             border;
    logic             v1;
    window_t          window;
    logic             unused_bits;

    assign pix_bit     = img_data_i[PIX_W-1];
    assign unused_bits = ^img_data_i[PIX_W-2:0];

    // vsync relocates the pixel presented in the same cycle to (0,0).
    assign col_cur  = vsync_i ? '0 : col;
    assign row_cur  = vsync_i ? '0 : row;
    assign last_col = (col_cur == COL_W'(IMG_WIDTH - 1));
    assign last_row = (row_cur == ROW_W'(IMG_HEIGHT - 1));

    line_buffer_1b #(.DEPTH(IMG_WIDTH)) u_lb1 (
        .clk  (clk),
        .we   (valid_i),
        .addr (col_cur),
        .din  (pix_bit),
        .dout (t1)
    );

    line_buffer_1b #(.DEPTH(IMG_WIDTH)) u_lb2 (
        .clk  (clk),
        .we   (valid_i),
        .addr (col_cur),
        .din  (t1),
        .dout (t2)
    );

    // Position of the next input pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (valid_i) begin
            col <= last_col ? '0 : col_cur + COL_W'(1);
            if (last_col) begin
                row <= last_row ? '0 : row_cur + ROW_W'(1);
            end else begin
                row <= row_cur;
            end
        end else if (vsync_i) begin
            col <= '0;
            row <= '0;
        end
    end

    // Stage 1: window shift and border capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            window <= '0;
            border <= 1'b1;
            v1     <= 1'b0;
        end else begin
            v1 <= valid_i;
            if (valid_i) begin
                window.top <= {window.top[1:0], t2};
                window.mid <= {window.mid[1:0], t1};
                window.bot <= {window.bot[1:0], pix_bit};
                border     <= (row_cur < ROW_W'(2)) || (col_cur < COL_W'(2));
            end
        end
    end

    // Stage 2: AND-reduce the window; data holds between valid outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_o    <= 1'b0;
            img_data_o <= BLACK;
        end else begin
            valid_o <= v1;
            if (v1) begin
                img_data_o <= border ? BLACK : replicate(&window);
            end
        end
    end
endmodule

// File: tb/tb_img_erode3x3.sv
// Directed bench for img_erode3x3 with an image-level erosion model and literal spot checks.
module tb_img_erode3x3;
    import img_pkg::*;

    localparam int W = 8;
    localparam int H = 6;

    logic             clk;
    logic             reset;
    logic             vsync_i;
    logic [PIX_W-1:0] img_data_i;
    logic             valid_i;
    logic [PIX_W-1:0] img_data_o;
    logic             valid_o;

    img_erode3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk        (clk),
        .reset      (reset),
        .vsync_i    (vsync_i),
        .img_data_i (img_data_i),
        .valid_i    (valid_i),
        .img_data_o (img_data_o),
        .valid_o    (valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [PIX_W-1:0] cap[$];
    logic [PIX_W-1:0] ref_white[$];

    // Model: the frame as a 2-D array, erosion evaluated directly on it.
    bit               img [H][W];
    int               m_row, m_col;
    bit               p1_v;
    logic [PIX_W-1:0] p1_d;
    logic             exp_v;
    logic [PIX_W-1:0] exp_d;

    function automatic bit erode_at(int r, int c);
        if (r < 2 || c < 2) return 1'b0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                if (!img[r-dr][c-dc]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_row = 0; m_col = 0; p1_v = 1'b0; p1_d = BLACK;
            exp_v = 1'b0; exp_d = BLACK;
        end else begin
            exp_v = p1_v;
            if (p1_v) exp_d = p1_d;
            p1_v = 1'b0;
            if (vsync_i) begin m_row = 0; m_col = 0; end
            if (valid_i) begin
                img[m_row][m_col] = img_data_i[23];
                p1_v = 1'b1;
                p1_d = erode_at(m_row, m_col) ? WHITE : BLACK;
                m_col++;
                if (m_col == W) begin
                    m_col = 0;
                    m_row++;
                    if (m_row == H) m_row = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle_check();
        check("valid_o", {31'd0, valid_o}, {31'd0, exp_v});
        check("img_data_o", {8'd0, img_data_o}, {8'd0, exp_d});
        if (valid_o) cap.push_back(img_data_o);
    endtask

    // Called at a negedge: check outputs, then present the next input for one cycle.
    task automatic drive(input bit v, input bit b, input bit vs);
        cycle_check();
        valid_i    = v;
        img_data_i = b ? WHITE : BLACK;
        vsync_i    = vs;
        @(negedge clk);
    endtask

    task automatic send_pixels(input int n, input int blk_r, input int blk_c, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) drive(1'b0, 1'b0, 1'b0);
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) drive(1'b0, 1'b0, 1'b0);
            drive(1'b1, !((i / W) == blk_r && (i % W) == blk_c), 1'b0);
        end
    endtask

    task automatic drain();
        repeat (4) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic cmp_seq(input string name, input int off_a, input int off_b, input int len);
        int nmis;
        nmis = 0;
        for (int i = 0; i < len; i++)
            if (cap[off_a + i] !== ref_white[off_b + i]) nmis++;
        check(name, 32'(nmis), 32'd0);
    endtask

    initial begin
        int zeros;
        reset = 1'b1; valid_i = 1'b0; vsync_i = 1'b0; img_data_i = BLACK;
        @(negedge clk);
        check("reset valid_o", {31'd0, valid_o}, 32'd0);
        check("reset img_data_o", {8'd0, img_data_o}, 32'h0);
        drive(1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // All-white frame, continuous.
        cap.delete();
        send_pixels(W*H, -1, -1, 0);
        drain();
        check("white count", 32'(cap.size()), 32'(W*H));
        check("white (0,0)", {8'd0, cap[0]}, 32'h0);
        check("white (1,7)", {8'd0, cap[15]}, 32'h0);
        check("white (2,1)", {8'd0, cap[17]}, 32'h0);
        check("white (2,2)", {8'd0, cap[18]}, 32'hFFFFFF);
        check("white (5,7)", {8'd0, cap[47]}, 32'hFFFFFF);
        ref_white = cap;

        // Single black pixel at (3,4).
        cap.delete();
        send_pixels(W*H, 3, 4, 0);
        drain();
        check("blk count", 32'(cap.size()), 32'(W*H));
        check("blk (3,4)", {8'd0, cap[28]}, 32'h0);
        check("blk (3,6)", {8'd0, cap[30]}, 32'h0);
        check("blk (4,5)", {8'd0, cap[37]}, 32'h0);
        check("blk (5,6)", {8'd0, cap[46]}, 32'h0);
        check("blk (3,3)", {8'd0, cap[27]}, 32'hFFFFFF);
        check("blk (2,4)", {8'd0, cap[20]}, 32'hFFFFFF);
        check("blk (5,7)", {8'd0, cap[47]}, 32'hFFFFFF);

        // White frame with random input gaps.
        cap.delete();
        send_pixels(W*H, -1, -1, 40);
        drain();
        check("gap count", 32'(cap.size()), 32'(W*H));
        if (cap.size() == W*H) cmp_seq("gap sequence", 0, 0, W*H);

        // Two back-to-back frames, no vsync.
        cap.delete();
        send_pixels(W*H, -1, -1, 0);
        send_pixels(W*H, -1, -1, 0);
        drain();
        check("b2b count", 32'(cap.size()), 32'(2*W*H));
        if (cap.size() == 2*W*H) begin
            cmp_seq("b2b frame0", 0, 0, W*H);
            cmp_seq("b2b frame1", W*H, 0, W*H);
        end

        // vsync mid-line at (2,5), then a fresh white frame.
        send_pixels(2*W + 5, -1, -1, 0);
        drain();
        cap.delete();
        drive(1'b0, 1'b0, 1'b1);
        send_pixels(W*H, -1, -1, 0);
        drain();
        check("vsync count", 32'(cap.size()), 32'(W*H));
        zeros = 0;
        for (int i = 0; i < 2*W && i < cap.size(); i++) if (cap[i] === BLACK) zeros++;
        check("vsync first two lines zero", 32'(zeros), 32'(2*W));
        check("vsync (2,1)", {8'd0, cap[17]}, 32'h0);
        check("vsync (2,2)", {8'd0, cap[18]}, 32'hFFFFFF);

        // Reset asserted during row 3.
        send_pixels(3*W + 4, -1, -1, 0);
        check("pre-reset valid_o", {31'd0, valid_o}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("async reset valid_o", {31'd0, valid_o}, 32'd0);
        check("async reset img_data_o", {8'd0, img_data_o}, 32'h0);
        valid_i = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        cap.delete();
        send_pixels(W*H, -1, -1, 0);
        drain();
        check("post-reset count", 32'(cap.size()), 32'(W*H));
        if (cap.size() == W*H) cmp_seq("post-reset frame", 0, 0, W*H);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
